// File: rtl/pc_seq_pkg.sv
// Shared state, redirect-source encodings and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2,
    SRC_EXC    = 2'd3
  } redir_src_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Priority mux for PC redirects (exc > jump > branch). With PC_SEQ_ALIGN_CHECK_EN defined,
// a misaligned jump/branch target is replaced by the exception vector and flagged.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(32'h0000_0080)
) (
  input  logic              exc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              redir,
  output logic [ADDR_W-1:0] target
`ifdef PC_SEQ_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  redir_src_e        src;
  logic [ADDR_W-1:0] raw_target;

  always_comb begin
    src = SRC_NONE;
    if (exc)               src = SRC_EXC;
    else if (jump)         src = SRC_JUMP;
    else if (branch_taken) src = SRC_BRANCH;
  end

  always_comb begin
    case (src)
      SRC_EXC:    raw_target = EXC_VEC;
      SRC_JUMP:   raw_target = jump_target;
      SRC_BRANCH: raw_target = branch_target;
      default:    raw_target = '0;
    endcase
  end

  assign redir = (src != SRC_NONE);

`ifdef PC_SEQ_ALIGN_CHECK_EN
  // The exception vector itself is never checked, so exc can never raise a fault.
  assign misaligned = ((src == SRC_JUMP) || (src == SRC_BRANCH)) && (raw_target[1:0] != 2'b00);
  assign target     = misaligned ? EXC_VEC : raw_target;
`else
  assign target = raw_target;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: req/ack fetch FSM, output register and one-entry skid.
// Optional misaligned-target trap enabled by defining PC_SEQ_ALIGN_CHECK_EN (adds align_fault).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               exc,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               fetch_req,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic               fetch_ack,
  input  logic [INSTR_W-1:0] fetch_instr,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4
`ifdef PC_SEQ_ALIGN_CHECK_EN
  ,
  output logic               align_fault
`endif
);

  seq_state_e         state_q;
  logic [ADDR_W-1:0]  pc_q, fetch_addr_q;
  logic               squash_q;
  logic               if_valid_q, skid_valid_q;
  logic [INSTR_W-1:0] if_instr_q, skid_instr_q;
  logic [ADDR_W-1:0]  if_pc_q, if_pc4_q, skid_pc_q, skid_pc4_q;

  logic               redir;
  logic [ADDR_W-1:0]  redir_target;
  logic [ADDR_W-1:0]  pc_plus4;
  logic               in_req, out_free, req_pending;

  assign pc_plus4    = pc_q + ADDR_W'(INSTR_BYTES);
  assign in_req      = (state_q == REQ);
  assign out_free    = !if_valid_q || !stall;
  // A request still waiting for its ack cannot be withdrawn; its data must be squashed later.
  assign req_pending = in_req && !fetch_ack;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic misaligned;
  logic align_fault_q;
`endif

  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .EXC_VEC(EXC_VEC)
  ) u_next_sel (
    .exc          (exc),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .redir        (redir),
    .target       (redir_target)
`ifdef PC_SEQ_ALIGN_CHECK_EN
    ,
    .misaligned   (misaligned)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VEC;
      fetch_addr_q <= RESET_VEC;
      squash_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pc4_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
    end else if (redir) begin
      state_q      <= REQ;
      pc_q         <= redir_target;
      if_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      squash_q     <= req_pending;
      if (!req_pending) fetch_addr_q <= redir_target;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (fetch_ack && !squash_q) begin
            pc_q         <= pc_plus4;
            fetch_addr_q <= pc_plus4;
            if (out_free) begin
              if_valid_q <= 1'b1;
              if_instr_q <= fetch_instr;
              if_pc_q    <= pc_q;
              if_pc4_q   <= pc_plus4;
            end else begin
              skid_valid_q <= 1'b1;
              skid_instr_q <= fetch_instr;
              skid_pc_q    <= pc_q;
              skid_pc4_q   <= pc_plus4;
              state_q      <= HOLD;
            end
          end else begin
            // Ack of a squashed request: drop it and start fetching the redirect target.
            if (fetch_ack) begin
              squash_q     <= 1'b0;
              fetch_addr_q <= pc_q;
            end
            if (out_free) if_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (out_free) begin
            if_valid_q   <= skid_valid_q;
            if_instr_q   <= skid_instr_q;
            if_pc_q      <= skid_pc_q;
            if_pc4_q     <= skid_pc4_q;
            skid_valid_q <= 1'b0;
            state_q      <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) align_fault_q <= 1'b0;
    else     align_fault_q <= redir && misaligned;
  end
  assign align_fault = align_fault_q;
`endif

  assign fetch_req   = in_req;
  assign fetch_addr  = fetch_addr_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc4_q;

endmodule
